// File: rtl/fepu_pkg.sv
// fepu_pkg
// Shared definitions for the front-end peripheral bridge.
//   fepu_state_e     : bridge FSM states
//   SEL_*            : bit positions in the one-hot device select
//   IO_BASE_DEFAULT  : default value of addr[31:28] that marks the IO region
//   CNT_W            : width of the read-wait counter
package fepu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } fepu_state_e;

  localparam int SEL_LED  = 0;
  localparam int SEL_SEG  = 1;
  localparam int SEL_KB   = 2;
  localparam int SEL_DRAM = 31;

  localparam logic [3:0] IO_BASE_DEFAULT = 4'hF;

  localparam int CNT_W = 3;

endpackage

// File: rtl/fepu_addr_decode.sv
// fepu_addr_decode
// Combinational address decode into the one-hot device select.
// Only the address fields that matter are passed in.
//   i_region : addr[31:28]
//   i_idx    : addr[6:2], device index inside the IO region
//   o_sel    : one-hot select (all zero for a reserved IO index)
//   o_rsvd   : IO access to a reserved index (3..31)
module fepu_addr_decode
  import fepu_pkg::*;
#(
  parameter logic [3:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic [3:0]  i_region,
  input  logic [4:0]  i_idx,
  output logic [31:0] o_sel,
  output logic        o_rsvd
);

  always_comb begin
    o_sel  = '0;
    o_rsvd = 1'b0;
    if (i_region == IO_BASE) begin
      case (i_idx)
        5'd0:    o_sel[SEL_LED] = 1'b1;
        5'd1:    o_sel[SEL_SEG] = 1'b1;
        5'd2:    o_sel[SEL_KB]  = 1'b1;
        default: o_rsvd         = 1'b1;
      endcase
    end else begin
      o_sel[SEL_DRAM] = 1'b1;
    end
  end

endmodule

// File: rtl/fepu_bus_bridge.sv
// fepu_bus_bridge
// Bridge between the CPU data-memory port and the back-end peripheral unit.
// One load or store in flight; stores strobe the back end for one cycle,
// loads wait for synchronous read data and return it with a ready pulse.
// Optional feature macro: FEPU_BUS_ERR_EN (reserved IO accesses raise
// cpu_err instead of cpu_ready, suppress the strobe and keep cpu_rdata).
//   clk, rst          : clock, synchronous active-high reset
//   cpu_addr/wdata    : CPU request address and store data
//   cpu_we / cpu_re   : store / load request (store wins)
//   cpu_rdata         : registered load result
//   cpu_ready/cpu_err : one-cycle completion / bus-error pulse
//   select            : registered one-hot device select
//   FEPU_BEPU_w       : one-cycle write strobe
//   FEPU_BEPU_addr/data : registered address / store data
//   BEPU_FEPU_data    : synchronous read data from the back end
module fepu_bus_bridge
  import fepu_pkg::*;
#(
  parameter int         READ_WAIT = 1,
  parameter logic [3:0] IO_BASE   = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] select,
  output logic        FEPU_BEPU_w,
  output logic [31:0] FEPU_BEPU_addr,
  output logic [31:0] FEPU_BEPU_data,
  input  logic [31:0] BEPU_FEPU_data
);

  // READ spends its first cycle presenting the registered address to the
  // back end, then READ_WAIT further cycles; data is captured on the last
  // one, giving cpu_ready READ_WAIT+2 cycles after the sampling edge.
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(READ_WAIT);

  fepu_state_e      r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_sel, r_addr, r_data, r_rdata;
  logic             r_rsvd;

  logic [31:0]      w_dec_sel;
  logic             w_dec_rsvd;
  logic             w_latch, w_capture, w_complete, w_write;

  fepu_addr_decode #(.IO_BASE(IO_BASE)) u_dec (
    .i_region (cpu_addr[31:28]),
    .i_idx    (cpu_addr[6:2]),
    .o_sel    (w_dec_sel),
    .o_rsvd   (w_dec_rsvd)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_we) begin
          w_next  = ST_WRITE;
          w_latch = 1'b1;
        end else if (cpu_re) begin
          w_next  = ST_READ;
          w_latch = 1'b1;
        end
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_READ: begin
        if (r_cnt == W_LAST) begin
          w_capture = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    w_complete = (r_state == ST_WRITE) || (r_state == ST_DONE);
    w_write    = (r_state == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_rsvd  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_sel  <= w_dec_sel;
        r_addr <= cpu_addr;
        r_data <= cpu_wdata;
        r_rsvd <= w_dec_rsvd;
      end
      if (r_state == ST_READ)
        r_cnt <= w_capture ? '0 : r_cnt + CNT_W'(1);
      if (w_capture) begin
`ifdef FEPU_BUS_ERR_EN
        if (!r_rsvd) r_rdata <= BEPU_FEPU_data;
`else
        r_rdata <= r_rsvd ? 32'd0 : BEPU_FEPU_data;
`endif
      end
    end
  end

`ifdef FEPU_BUS_ERR_EN
  assign cpu_ready   = w_complete && !r_rsvd;
  assign cpu_err     = w_complete &&  r_rsvd;
  assign FEPU_BEPU_w = w_write    && !r_rsvd;
`else
  assign cpu_ready   = w_complete;
  assign cpu_err     = 1'b0;
  assign FEPU_BEPU_w = w_write;
`endif

  assign cpu_rdata      = r_rdata;
  assign select         = r_sel;
  assign FEPU_BEPU_addr = r_addr;
  assign FEPU_BEPU_data = r_data;

endmodule

// File: tb/tb_fepu_bus_bridge.sv
module tb_fepu_bus_bridge;

  localparam int RW = 1;
`ifdef FEPU_BUS_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, select;
  logic [31:0] FEPU_BEPU_addr, FEPU_BEPU_data, BEPU_FEPU_data;
  logic        cpu_we, cpu_re, cpu_ready, cpu_err, FEPU_BEPU_w;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] rd_model = 32'd0;
  logic        mon_en = 1'b0;
  logic        prev_w = 1'b0;

  fepu_bus_bridge #(.READ_WAIT(RW), .IO_BASE(4'hF)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .select(select), .FEPU_BEPU_w(FEPU_BEPU_w),
    .FEPU_BEPU_addr(FEPU_BEPU_addr), .FEPU_BEPU_data(FEPU_BEPU_data),
    .BEPU_FEPU_data(BEPU_FEPU_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_io(input logic [31:0] a);
    return (a >> 28) == 32'd15;
  endfunction

  function automatic int dev_idx(input logic [31:0] a);
    return int'((a >> 2) % 32);
  endfunction

  function automatic bit is_rsvd(input logic [31:0] a);
    return is_io(a) && dev_idx(a) >= 3;
  endfunction

  function automatic logic [31:0] exp_sel(input logic [31:0] a);
    if (!is_io(a)) return 32'h8000_0000;
    if (dev_idx(a) < 3) return 32'd1 << dev_idx(a);
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe must never be high in two consecutive cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      assert (!(FEPU_BEPU_w && prev_w)) else begin
        n_fail++;
        $error("FAIL strobe_run: observed %b expected %b", 2'b11, 2'b01);
      end
    end
    prev_w <= FEPU_BEPU_w;
  end

  // Called at a negedge in an IDLE cycle; returns at a negedge in IDLE.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both);
    bit err_case;
    err_case = ERR && is_rsvd(a);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_re = both;
    @(posedge clk); #1;
    chk("st_w",     {31'd0, FEPU_BEPU_w}, {31'd0, !err_case});
    chk("st_ready", {31'd0, cpu_ready},   {31'd0, !err_case});
    chk("st_err",   {31'd0, cpu_err},     {31'd0, err_case});
    chk("st_sel",   select,         exp_sel(a));
    chk("st_addr",  FEPU_BEPU_addr, a);
    chk("st_data",  FEPU_BEPU_data, d);
    chk("st_rdata", cpu_rdata,      rd_model);
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
    @(posedge clk); #1;
    chk("st_w_off",     {31'd0, FEPU_BEPU_w}, 32'd0);
    chk("st_ready_off", {31'd0, cpu_ready},   32'd0);
    chk("st_sel_hold",  select, exp_sel(a));
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] bd);
    bit err_case;
    err_case = ERR && is_rsvd(a);
    cpu_addr = a; cpu_wdata = $urandom; cpu_re = 1'b1; cpu_we = 1'b0;
    BEPU_FEPU_data = bd;
    for (int k = 1; k <= RW + 2; k++) begin
      @(posedge clk); #1;
      chk("ld_ready", {31'd0, cpu_ready},   {31'd0, (k == RW + 2) && !err_case});
      chk("ld_err",   {31'd0, cpu_err},     {31'd0, (k == RW + 2) && err_case});
      chk("ld_w",     {31'd0, FEPU_BEPU_w}, 32'd0);
      chk("ld_sel",   select, exp_sel(a));
      if (k == 1) chk("ld_rdata_old", cpu_rdata, rd_model);
    end
    if (!err_case) rd_model = is_rsvd(a) ? 32'd0 : bd;
    chk("ld_rdata", cpu_rdata, rd_model);
    chk("ld_addr",  FEPU_BEPU_addr, a);
    @(negedge clk);
    cpu_re = 1'b0;
    @(posedge clk); #1;
    chk("ld_ready_off", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   select, 32'd0);
    chk({tag, "_addr"},  FEPU_BEPU_addr, 32'd0);
    chk({tag, "_data"},  FEPU_BEPU_data, 32'd0);
    chk({tag, "_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_flags"}, {29'd0, FEPU_BEPU_w, cpu_ready, cpu_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    BEPU_FEPU_data = '0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    do_store(32'hF000_0000, 32'h0000_00A5, 1'b0);       // LED store
    do_load (32'h0000_0010, 32'hDEAD_BEEF);             // DRAM load
    do_store(32'hF000_0004, 32'h1234_5678, 1'b1);       // we+re -> store
    do_load (32'hF000_0020, 32'hCAFE_F00D);             // reserved index 8
    do_store(32'hF000_0004, 32'h0000_0001, 1'b0);       // back-to-back pair
    do_store(32'hF000_0004, 32'h0000_0002, 1'b0);
    do_store(32'hF000_007C, 32'h5555_AAAA, 1'b0);       // reserved index 31
    do_load (32'hF000_0008, 32'h0BAD_CAFE);             // keyboard load

    // Reset in the READ cycle aborts the load
    cpu_addr = 32'h0000_0010; cpu_re = 1'b1; BEPU_FEPU_data = 32'h1111_2222;
    @(posedge clk); #1;
    chk("abort_sel", select, 32'h8000_0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rd_model = 32'd0;
    chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b0; cpu_re = 1'b0;
    for (int k = 0; k < RW + 2; k++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", {30'd0, cpu_ready, cpu_err}, 32'd0);
    end
    @(negedge clk);
    do_store(32'hF000_0004, 32'h0000_00C3, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: a = {4'hF, 21'($urandom), 5'($urandom_range(0, 2)), 2'b00};
        1: a = {4'hF, 21'($urandom), 5'($urandom_range(3, 31)), 2'b00};
        default: a = {4'($urandom_range(0, 14)), 28'($urandom)};
      endcase
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_store(a, d, 1'($urandom_range(0, 1)));
      else                           do_load(a, d);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
